// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO, 2**addrsize words of datasize bits, with registered read data.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module asynchronous_fifo #(
   parameter int datasize = 8,
   parameter int addrsize = 4
) (
   input  logic                clk1,
   input  logic                rst1,
   input  logic                w_en,
   input  logic                r_en,
   input  logic [datasize-1:0] wdata,
   output logic [datasize-1:0] rdata,
   output logic                full,
   output logic                empty
);

   localparam int depth = 1 << addrsize;
   localparam logic [addrsize:0] ptr_one = {{addrsize{1'b0}}, 1'b1};

   logic [datasize-1:0] mem [depth];
   logic [addrsize:0]   wptr;
   logic [addrsize:0]   rptr;
   logic                w_accept;
   logic                r_accept;

   // Same low bits with different wrap bits means the writer is a full lap ahead.
   assign empty    = (wptr == rptr);
   assign full     = (wptr[addrsize] != rptr[addrsize]) &&
                     (wptr[addrsize-1:0] == rptr[addrsize-1:0]);
   assign w_accept = w_en && !full;
   assign r_accept = r_en && !empty;

   // NOTE: storage array has no reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clk1) begin
      if (w_accept && rst1) begin
         mem[wptr[addrsize-1:0]] <= wdata;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk1 or negedge rst1) begin
      if (!rst1) begin
         wptr <= '0;
      end else if (w_accept) begin
         wptr <= wptr + ptr_one;
      end
   end

   always_ff @(posedge clk1 or negedge rst1) begin
      if (!rst1) begin
         rptr  <= '0;
         rdata <= '0;
      end else if (r_accept) begin
         rptr  <= rptr + ptr_one;
         rdata <= mem[rptr[addrsize-1:0]];
      end
   end

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Self-checking bench for asynchronous_fifo: queue scoreboard predicts rdata and flags.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
module tb_asynchronous_fifo;

   localparam int depth = 16;

   logic       clk1 = 1'b0;
   logic       rst1;
   logic       w_en;
   logic       r_en;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       full;
   logic       empty;

   logic [7:0] q[$];
   logic [7:0] exp_rdata;
   int         tests_run    = 0;
   int         tests_failed = 0;

   asynchronous_fifo #(.datasize(8), .addrsize(4)) dut (
      .clk1 (clk1),
      .rst1 (rst1),
      .w_en (w_en),
      .r_en (r_en),
      .wdata(wdata),
      .rdata(rdata),
      .full (full),
      .empty(empty)
   );

   always #5 clk1 = ~clk1;

   // Drive one cycle and advance the reference model using pre-edge occupancy.
   task automatic step(input logic w, input logic r, input logic [7:0] d);
      bit wa;
      bit ra;
      w_en  = w;
      r_en  = r;
      wdata = d;
      @(posedge clk1);
      wa = w && (q.size() < depth);
      ra = r && (q.size() != 0);
      if (ra) exp_rdata = q.pop_front();
      if (wa) q.push_back(d);
      @(negedge clk1);
   endtask

   task automatic test_reset();
      w_en  = 1'b0;
      r_en  = 1'b0;
      wdata = 8'h00;
      rst1  = 1'b0;
      q.delete();
      exp_rdata = 8'h00;
      #1;
      for (int i = 0; i < 2; i++) begin
         w_en = ~w_en;
         r_en = (i == 0);
         wdata = 8'h5A;
         @(negedge clk1);
         tests_run++;
         if (empty !== 1'b1 || full !== 1'b0 || rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_hold cyc%0d: empty=%b full=%b rdata=%h, want 1 0 00", i, empty, full, rdata);
         end
      end
      w_en = 1'b0;
      r_en = 1'b0;
      rst1 = 1'b1;
      @(negedge clk1);
      tests_run++;
      if (empty !== 1'b1 || full !== 1'b0 || rdata !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_release: empty=%b full=%b rdata=%h, want 1 0 00", empty, full, rdata);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < depth; i++) begin
         step(1'b1, 1'b0, 8'(i));
         tests_run++;
         if (full !== (i == depth - 1) || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_flags w%0d: full=%b empty=%b, want %b 0", i, full, empty, (i == depth - 1));
         end
      end
      step(1'b1, 1'b0, 8'hAA);
      tests_run++;
      if (full !== 1'b1 || q.size() != depth) begin
         tests_failed++;
         $display("FAIL fill_overflow: full=%b, want 1", full);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < depth; i++) begin
         step(1'b0, 1'b1, 8'h00);
         tests_run++;
         if (rdata !== 8'(i) || rdata !== exp_rdata || empty !== (i == depth - 1) || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain r%0d: rdata=%h empty=%b full=%b, want %h %b 0", i, rdata, empty, full, 8'(i), (i == depth - 1));
         end
      end
      step(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (rdata !== 8'h0F || empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL drain_extra: rdata=%h empty=%b, want 0f 1", rdata, empty);
      end
   endtask

   task automatic test_wrap();
      int base;
      base = 0;
      for (int phase = 0; phase < 2; phase++) begin
         int n;
         n = (phase == 0) ? 10 : 12;
         for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h20 + 8'(base + i));
         for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 8'h00);
            tests_run++;
            if (rdata !== (8'h20 + 8'(base + i)) || rdata !== exp_rdata) begin
               tests_failed++;
               $display("FAIL wrap p%0d r%0d: rdata=%h, want %h", phase, i, rdata, 8'h20 + 8'(base + i));
            end
         end
         base += n;
      end
      tests_run++;
      if (empty !== 1'b1 || full !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_final: empty=%b full=%b, want 1 0", empty, full);
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < depth; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
      step(1'b1, 1'b1, 8'h99);
      tests_run++;
      if (rdata !== 8'h40 || full !== 1'b0 || empty !== 1'b0) begin
         tests_failed++;
         $display("FAIL simul_full: rdata=%h full=%b empty=%b, want 40 0 0", rdata, full, empty);
      end
      for (int i = 1; i < depth; i++) begin
         step(1'b0, 1'b1, 8'h00);
         tests_run++;
         if (rdata !== (8'h40 + 8'(i))) begin
            tests_failed++;
            $display("FAIL simul_drain r%0d: rdata=%h, want %h", i, rdata, 8'h40 + 8'(i));
         end
      end
      step(1'b1, 1'b1, 8'h77);
      tests_run++;
      if (rdata !== 8'h4F || empty !== 1'b0 || full !== 1'b0) begin
         tests_failed++;
         $display("FAIL simul_empty: rdata=%h empty=%b full=%b, want 4f 0 0", rdata, empty, full);
      end
      step(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (rdata !== 8'h77 || empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_followup: rdata=%h empty=%b, want 77 1", rdata, empty);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         if (c == 150) begin
            rst1 = 1'b0;
            #1;
            q.delete();
            exp_rdata = 8'h00;
            tests_run++;
            if (empty !== 1'b1 || full !== 1'b0 || rdata !== 8'h00) begin
               tests_failed++;
               $display("FAIL random_reset: empty=%b full=%b rdata=%h, want 1 0 00", empty, full, rdata);
            end
            @(negedge clk1);
            rst1 = 1'b1;
         end
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
         tests_run++;
         if (rdata !== exp_rdata || empty !== (q.size() == 0) || full !== (q.size() == depth)) begin
            tests_failed++;
            $display("FAIL random c%0d: rdata=%h empty=%b full=%b, want %h %b %b", c, rdata, empty, full,
                     exp_rdata, (q.size() == 0), (q.size() == depth));
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
